// File: rtl/hazard_controller.sv
// hazard_controller: pipeline stall/flush/bubble control, EX forwarding and data-memory wait/timeout sequencing
module hazard_controller #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic             MemReadE,
    input  logic             PCSrcE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             BubbleE,
    output logic             HoldE,
    output logic             HoldM,
    output logic             BubbleW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MemFault,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);
    typedef enum logic [1:0] {RUN, MEMWAIT, FAULT} state_t;

    localparam int WCW = $clog2(MEM_TIMEOUT + 2);
    localparam logic [WCW-1:0] LAST = WCW'(MEM_TIMEOUT == 0 ? 0 : MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             lu, mw, fault, en, hold, to_fault;

    // EX forwarding: MEM result has priority over WB; x0 is never forwarded
    always_comb begin
        ForwardAE = (RegWriteM && RdM != 5'd0 && RdM == Rs1E) ? 2'b10 :
                    (RegWriteW && RdW != 5'd0 && RdW == Rs1E) ? 2'b01 : 2'b00;
        ForwardBE = (RegWriteM && RdM != 5'd0 && RdM == Rs2E) ? 2'b10 :
                    (RegWriteW && RdW != 5'd0 && RdW == Rs2E) ? 2'b01 : 2'b00;
    end

    // Pipeline controls: fault/mem-wait hold beats redirect, redirect beats load-use
    always_comb begin
        lu      = MemReadE && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);
        mw      = MemReqM && !MemReadyM;
        fault   = state_q == FAULT;
        en      = reset || fault;
        hold    = fault || mw;
        StallF  = en && (hold || (!PCSrcE && lu));
        StallD  = StallF;
        FlushD  = en && !hold && PCSrcE;
        BubbleE = en && !hold && (PCSrcE || lu);
        HoldE   = en && hold;
        HoldM   = en && hold;
        BubbleW = en && hold;
    end

    // Next state: wait sequencing, timeout detection and saturating counters
    always_comb begin
        to_fault    = MEM_TIMEOUT != 0 && mw && wait_cnt_q == LAST;
        wait_cnt_d  = mw ? wait_cnt_q + WCW'(1) : '0;
        state_d     = fault    ? FAULT :
                      to_fault ? FAULT :
                      (mw || (state_q == MEMWAIT && !MemReadyM)) ? MEMWAIT : RUN;
        stall_cnt_d = (StallF && !fault && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
        flush_cnt_d = (FlushD && flush_cnt_q != '1) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign MemFault   = fault;
    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed vector table plus multi-cycle sequences for hazard_controller
module tb_hazard_controller;
    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       MemReadE, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;

    logic        sf0, sd0, fd0, be0, he0, hm0, bw0, mf0;
    logic [1:0]  fa0, fb0;
    logic [15:0] sc0, fc0;
    logic        sf1, sd1, fd1, be1, he1, hm1, bw1, mf1;
    logic [1:0]  fa1, fb1;
    logic [1:0]  sc1, fc1;
    logic [6:0]  ctl0, ctl1;

    int tests = 0;
    int fails = 0;

    localparam logic [6:0] NONE = 7'b0000000;
    localparam logic [6:0] LU   = 7'b1101000;
    localparam logic [6:0] BR   = 7'b0011000;
    localparam logic [6:0] HOLD = 7'b1100111;

    always #5 clk = ~clk;

    assign ctl0 = {sf0, sd0, fd0, be0, he0, hm0, bw0};
    assign ctl1 = {sf1, sd1, fd1, be1, he1, hm1, bw1};

    hazard_controller u0 (
        .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .MemReadE(MemReadE), .PCSrcE(PCSrcE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM),
        .RegWriteW(RegWriteW), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(sf0), .StallD(sd0), .FlushD(fd0), .BubbleE(be0), .HoldE(he0), .HoldM(hm0),
        .BubbleW(bw0), .ForwardAE(fa0), .ForwardBE(fb0), .MemFault(mf0),
        .StallCount(sc0), .FlushCount(fc0)
    );

    hazard_controller #(.MEM_TIMEOUT(4), .CNT_W(2)) u1 (
        .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .MemReadE(MemReadE), .PCSrcE(PCSrcE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM),
        .RegWriteW(RegWriteW), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(sf1), .StallD(sd1), .FlushD(fd1), .BubbleE(be1), .HoldE(he1), .HoldM(hm1),
        .BubbleW(bw1), .ForwardAE(fa1), .ForwardBE(fb1), .MemFault(mf1),
        .StallCount(sc1), .FlushCount(fc1)
    );

    typedef struct packed {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic       mre, pc, rwm, rww, req, rdy;
        logic [6:0] ctl;
        logic [1:0] fa, fb;
    } vec_t;

    vec_t vec [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        {MemReadE, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM} = '0;
    endtask

    task automatic set_lu();
        MemReadE = 1'b1;
        RdE      = 5'd7;
        Rs2D     = 5'd7;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        //         rs1d  rs2d  rs1e  rs2e  rde   rdm   rdw   mre  pc   rwm  rww  req  rdy  ctl   fa     fb
        vec[0]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, NONE, 2'b00, 2'b00};
        vec[1]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 1'b0,1'b0,1'b1,1'b1,1'b0,1'b0, NONE, 2'b10, 2'b00};
        vec[2]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, NONE, 2'b01, 2'b00};
        vec[3]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b1,1'b1,1'b0,1'b0, NONE, 2'b00, 2'b00};
        vec[4]  = '{5'd0, 5'd0, 5'd4, 5'd3, 5'd0, 5'd3, 5'd4, 1'b0,1'b0,1'b1,1'b1,1'b0,1'b0, NONE, 2'b01, 2'b10};
        vec[5]  = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, LU,   2'b00, 2'b00};
        vec[6]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, NONE, 2'b00, 2'b00};
        vec[7]  = '{5'd9, 5'd1, 5'd0, 5'd0, 5'd9, 5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, LU,   2'b00, 2'b00};
        vec[8]  = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, NONE, 2'b00, 2'b00};
        vec[9]  = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, BR,   2'b00, 2'b00};
        vec[10] = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b1,1'b1,1'b0,1'b0,1'b1,1'b0, HOLD, 2'b00, 2'b00};
        vec[11] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, NONE, 2'b00, 2'b00};

        idle();
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Reset gating: load-use while reset is low yields no stall
        set_lu();
        #1 check("reset_gate_stall", {31'd0, sf0}, 32'd0);
        do_reset();
        #1;
        check("rst_ctl", {25'd0, ctl0}, {25'd0, NONE});
        check("rst_fwd", {28'd0, fa0, fb0}, 32'd0);
        check("rst_fault", {30'd0, mf0, mf1}, 32'd0);
        check("rst_cnt", {sc0, fc0}, 32'd0);

        // Combinational vector table
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} =
                {vec[i].rs1d, vec[i].rs2d, vec[i].rs1e, vec[i].rs2e, vec[i].rde, vec[i].rdm, vec[i].rdw};
            {MemReadE, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM} =
                {vec[i].mre, vec[i].pc, vec[i].rwm, vec[i].rww, vec[i].req, vec[i].rdy};
            #1;
            check($sformatf("vec%0d_ctl", i), {25'd0, ctl0}, {25'd0, vec[i].ctl});
            check($sformatf("vec%0d_fa", i), {30'd0, fa0}, {30'd0, vec[i].fa});
            check($sformatf("vec%0d_fb", i), {30'd0, fb0}, {30'd0, vec[i].fb});
        end

        // Load-use costs one cycle; next cycle the load is forwarded from MEM
        do_reset();
        set_lu();
        #1 check("lu_stall", {25'd0, ctl0}, {25'd0, LU});
        @(negedge clk);
        idle();
        RegWriteM = 1'b1; RdM = 5'd7; Rs2E = 5'd7;
        #1;
        check("lu_after_ctl", {25'd0, ctl0}, {25'd0, NONE});
        check("lu_after_fwd", {30'd0, fb0}, 32'd2);
        check("lu_stallcnt", {16'd0, sc0}, 32'd1);

        // Branch overrides load-use
        do_reset();
        set_lu();
        PCSrcE = 1'b1;
        #1 check("br_lu_ctl", {25'd0, ctl0}, {25'd0, BR});
        @(negedge clk);
        idle();
        #1;
        check("br_flushcnt", {16'd0, fc0}, 32'd1);
        check("br_stallcnt", {16'd0, sc0}, 32'd0);

        // Three not-ready cycles with a pending redirect, then ready
        do_reset();
        MemReqM = 1'b1; PCSrcE = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            if (c > 1) @(negedge clk);
            #1 check($sformatf("mw_hold%0d", c), {25'd0, ctl0}, {25'd0, HOLD});
        end
        @(negedge clk);
        MemReadyM = 1'b1;
        #1 check("mw_ready_flush", {25'd0, ctl0}, {25'd0, BR});
        @(negedge clk);
        idle();
        #1;
        check("mw_release", {25'd0, ctl0}, {25'd0, NONE});
        check("mw_stallcnt", {16'd0, sc0}, 32'd3);
        check("mw_flushcnt", {16'd0, fc0}, 32'd1);
        check("mw_nofault4", {31'd0, mf1}, 32'd0);

        // Timeout of 4 on u1: fault visible from cycle 5, sticky past ready
        do_reset();
        MemReqM = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) @(negedge clk);
            #1 check($sformatf("to_fault_c%0d", c), {31'd0, mf1}, {31'd0, c == 5});
        end
        @(negedge clk);
        MemReqM = 1'b0; MemReadyM = 1'b1;
        #1;
        check("to_fault_hold", {25'd0, ctl1}, {25'd0, HOLD});
        check("to_nofault_u0", {24'd0, ctl0, mf0}, 32'd0);
        check("to_stall_sat", {30'd0, sc1}, 32'd3);
        check("to_stall_u0", {16'd0, sc0}, 32'd5);
        @(negedge clk);
        reset = 1'b0;
        #1 check("to_fault_in_rst", {31'd0, sf1}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        idle();
        #1;
        check("to_rst_fault", {31'd0, mf1}, 32'd0);
        check("to_rst_cnt", {28'd0, sc1, fc1}, 32'd0);
        check("to_rst_ctl", {25'd0, ctl1}, {25'd0, NONE});

        // Five load-use stalls: 2-bit counter saturates
        do_reset();
        set_lu();
        repeat (5) @(negedge clk);
        idle();
        #1;
        check("sat_u1", {30'd0, sc1}, 32'd3);
        check("sat_u0", {16'd0, sc0}, 32'd5);

        // Default timeout of 15 on u0: fault visible from cycle 16
        do_reset();
        MemReqM = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            if (c > 1) @(negedge clk);
            #1;
            if (c >= 15) check($sformatf("to15_c%0d", c), {31'd0, mf0}, {31'd0, c == 16});
        end
        do_reset();
        #1 check("final_rst", {30'd0, mf0, mf1}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
